// File: rtl/interleave_seq_ctrl_if.sv
// Handshake bundle between the parent ap_ctrl port, the sequencer and the LOAD/WRITE pipelines.
// master = sequencer side, slave = parent/children side; counter outputs exist only with SEQ_CYCLE_COUNT_EN.
interface interleave_seq_ctrl_if #(
  parameter int CNT_W = 2
) ();
  logic             ap_start;
  logic             ap_continue;
  logic             ap_idle;
  logic             ap_ready;
  logic             ap_done;
  logic             load_start;
  logic             load_ready;
  logic             load_done;
  logic             write_start;
  logic             write_ready;
  logic             write_done;
  logic [CNT_W-1:0] pass_idx;
  logic             bank_sel;
  logic             seq_err;
`ifdef SEQ_CYCLE_COUNT_EN
  logic [31:0]      load_cycles;
  logic [31:0]      write_cycles;

  modport master (
    input  ap_start, ap_continue, load_ready, load_done, write_ready, write_done,
    output ap_idle, ap_ready, ap_done, load_start, write_start, pass_idx, bank_sel, seq_err,
    output load_cycles, write_cycles
  );
  modport slave (
    output ap_start, ap_continue, load_ready, load_done, write_ready, write_done,
    input  ap_idle, ap_ready, ap_done, load_start, write_start, pass_idx, bank_sel, seq_err,
    input  load_cycles, write_cycles
  );
`else
  modport master (
    input  ap_start, ap_continue, load_ready, load_done, write_ready, write_done,
    output ap_idle, ap_ready, ap_done, load_start, write_start, pass_idx, bank_sel, seq_err
  );
  modport slave (
    output ap_start, ap_continue, load_ready, load_done, write_ready, write_done,
    input  ap_idle, ap_ready, ap_done, load_start, write_start, pass_idx, bank_sel, seq_err
  );
`endif
endinterface

// File: rtl/interleave_seq_ctrl.sv
// Alternates LOAD then WRITE pipeline starts for PASSES pass pairs per ap_ctrl invocation, all outputs registered.
// Optional SEQ_CYCLE_COUNT_EN adds saturating load_cycles/write_cycles occupancy counters.
module interleave_seq_ctrl #(
  parameter int PASSES = 4,
  parameter int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1
) (
  input logic                  clk,
  input logic                  rst,
  interleave_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LD_ST = 3'd1,
    LD_WT = 3'd2,
    WR_ST = 3'd3,
    WR_WT = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(PASSES - 1);

  state_t           state;
  logic             idle_q;
  logic             ready_q;
  logic             done_q;
  logic             load_start_q;
  logic             write_start_q;
  logic             bank_q;
  logic             err_q;
  logic [CNT_W-1:0] pass_q;

  logic in_load;
  logic in_write;
  logic write_fin;
  logic proto_err;

  always_comb begin
    in_load   = (state == LD_ST) || (state == LD_WT);
    in_write  = (state == WR_ST) || (state == WR_WT);
    write_fin = ((state == WR_ST) && bus.write_ready && bus.write_done) ||
                ((state == WR_WT) && bus.write_done);
    // ready is judged against the start actually being presented this cycle
    proto_err = (bus.load_done   && !in_load)       ||
                (bus.write_done  && !in_write)      ||
                (bus.load_ready  && !load_start_q)  ||
                (bus.write_ready && !write_start_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idle_q        <= 1'b1;
      ready_q       <= 1'b0;
      done_q        <= 1'b0;
      load_start_q  <= 1'b0;
      write_start_q <= 1'b0;
      bank_q        <= 1'b0;
      err_q         <= 1'b0;
      pass_q        <= '0;
    end else begin
      ready_q <= 1'b0;
      if (proto_err) begin
        err_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.ap_start) begin
            state        <= LD_ST;
            idle_q       <= 1'b0;
            load_start_q <= 1'b1;
            pass_q       <= '0;
            bank_q       <= 1'b0;
          end
        end
        LD_ST: begin
          if (bus.load_ready) begin
            load_start_q <= 1'b0;
            if (bus.load_done) begin
              state         <= WR_ST;
              write_start_q <= 1'b1;
            end else begin
              state <= LD_WT;
            end
          end
        end
        LD_WT: begin
          if (bus.load_done) begin
            state         <= WR_ST;
            write_start_q <= 1'b1;
          end
        end
        WR_ST: begin
          if (bus.write_ready) begin
            write_start_q <= 1'b0;
            if (!bus.write_done) begin
              state <= WR_WT;
            end
          end
        end
        WR_WT: begin
        end
        DONE: begin
          if (bus.ap_continue) begin
            state  <= IDLE;
            done_q <= 1'b0;
            idle_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // pass completion overrides the per-state next-state chosen above
      if (write_fin) begin
        if (pass_q == LAST_PASS) begin
          state   <= DONE;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
        end else begin
          state        <= LD_ST;
          load_start_q <= 1'b1;
          pass_q       <= pass_q + CNT_W'(1);
          bank_q       <= ~bank_q;
        end
      end
    end
  end

  assign bus.ap_idle     = idle_q;
  assign bus.ap_ready    = ready_q;
  assign bus.ap_done     = done_q;
  assign bus.load_start  = load_start_q;
  assign bus.write_start = write_start_q;
  assign bus.pass_idx    = pass_q;
  assign bus.bank_sel    = bank_q;
  assign bus.seq_err     = err_q;

`ifdef SEQ_CYCLE_COUNT_EN
  logic [31:0] load_cyc_q;
  logic [31:0] write_cyc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cyc_q  <= '0;
      write_cyc_q <= '0;
    end else if ((state == IDLE) && bus.ap_start) begin
      load_cyc_q  <= '0;
      write_cyc_q <= '0;
    end else begin
      if (in_load && (load_cyc_q != 32'hFFFF_FFFF)) begin
        load_cyc_q <= load_cyc_q + 32'd1;
      end
      if (in_write && (write_cyc_q != 32'hFFFF_FFFF)) begin
        write_cyc_q <= write_cyc_q + 32'd1;
      end
    end
  end

  assign bus.load_cycles  = load_cyc_q;
  assign bus.write_cycles = write_cyc_q;
`endif

endmodule

// File: tb/tb_interleave_seq_ctrl.sv
// Directed bench for interleave_seq_ctrl: scripted child pipelines, a pass-step model checked every cycle, plus literal pins.
`timescale 1ns/1ps
module tb_interleave_seq_ctrl;
  localparam int PASSES = 4;
  localparam int CNT_W  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  interleave_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();
  interleave_seq_ctrl #(.PASSES(PASSES), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model: an invocation is a sequence of 2*PASSES steps (even = load, odd = write).
  bit          m_busy, m_req, m_done, m_first, m_err;
  int          m_step;
  logic [31:0] m_lc, m_wc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_req = 0; m_done = 0; m_first = 0; m_err = 0; m_step = 0;
      m_lc = 0; m_wc = 0;
    end else begin
      bit cur_ls, cur_ws, rdy, dn, adv;
      cur_ls = m_busy && m_req && (m_step % 2 == 0);
      cur_ws = m_busy && m_req && (m_step % 2 == 1);
      if (bus.load_done  && !(m_busy && m_step % 2 == 0)) m_err = 1;
      if (bus.write_done && !(m_busy && m_step % 2 == 1)) m_err = 1;
      if ((bus.load_ready && !cur_ls) || (bus.write_ready && !cur_ws)) m_err = 1;
      if (!m_busy && !m_done && bus.ap_start) begin
        m_lc = 0; m_wc = 0;
      end else if (m_busy) begin
        if (m_step % 2 == 0) begin if (m_lc != 32'hFFFF_FFFF) m_lc++; end
        else begin if (m_wc != 32'hFFFF_FFFF) m_wc++; end
      end
      if (m_done) begin
        m_first = 0;
        if (bus.ap_continue) m_done = 0;
      end else if (!m_busy) begin
        if (bus.ap_start) begin m_busy = 1; m_step = 0; m_req = 1; end
      end else begin
        rdy = (m_step % 2 == 1) ? bus.write_ready : bus.load_ready;
        dn  = (m_step % 2 == 1) ? bus.write_done  : bus.load_done;
        adv = 0;
        if (m_req) begin
          if (rdy) begin m_req = 0; adv = dn; end
        end else begin
          adv = dn;
        end
        if (adv) begin
          if (m_step == 2 * PASSES - 1) begin m_busy = 0; m_done = 1; m_first = 1; end
          else begin m_step++; m_req = 1; end
        end
      end
    end
  end

  // Scripted child pipelines: ready after *_rdy start-high cycles, done *_dn cycles after ready.
  int l_rdy = 1, l_dn = 3, w_rdy = 1, w_dn = 3;
  int l_cnt, w_cnt;
  bit l_busy, w_busy;
  int inj_req = 0;
  int inj_done = 0;

  initial begin
    bus.load_ready = 0; bus.load_done = 0; bus.write_ready = 0; bus.write_done = 0;
    l_cnt = 0; w_cnt = 0; l_busy = 0; w_busy = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.load_ready = 0; bus.load_done = 0; bus.write_ready = 0; bus.write_done = 0;
      if (rst) begin
        l_cnt = 0; w_cnt = 0; l_busy = 0; w_busy = 0;
      end else begin
        if (inj_req != inj_done && l_busy) begin
          bus.write_done = 1;
          inj_done = inj_req;
        end
        if (l_busy) begin
          l_cnt++;
          if (l_cnt == l_dn) begin bus.load_done = 1; l_busy = 0; l_cnt = 0; end
        end else if (bus.load_start) begin
          l_cnt++;
          if (l_cnt >= l_rdy) begin
            bus.load_ready = 1; l_cnt = 0;
            if (l_dn == 0) bus.load_done = 1; else l_busy = 1;
          end
        end else l_cnt = 0;
        if (w_busy) begin
          w_cnt++;
          if (w_cnt == w_dn) begin bus.write_done = 1; w_busy = 0; w_cnt = 0; end
        end else if (bus.write_start) begin
          w_cnt++;
          if (w_cnt >= w_rdy) begin
            bus.write_ready = 1; w_cnt = 0;
            if (w_dn == 0) bus.write_done = 1; else w_busy = 1;
          end
        end else w_cnt = 0;
      end
    end
  end

  // Per-cycle compare against the model, plus event bookkeeping for the directed checks.
  int cyc = 0, clr_gen = 0, clr_seen = 0;
  int acc_cyc, done_cyc, wd_cyc, n_ls, n_ws, n_done, n_rdy, ls_run;
  bit ls_prev, ws_prev, ad_prev;
  int banks[$];
  int runs[$];

  always @(negedge clk) begin
    cyc++;
    if (clr_gen != clr_seen) begin
      clr_seen = clr_gen;
      acc_cyc = -100; done_cyc = -1; wd_cyc = -1000;
      n_ls = 0; n_ws = 0; n_done = 0; n_rdy = 0; ls_run = 0;
      banks.delete(); runs.delete();
    end
    if (!rst) begin
      chk("ap_idle",     bus.ap_idle,     !m_busy && !m_done);
      chk("ap_done",     bus.ap_done,     m_done);
      chk("ap_ready",    bus.ap_ready,    m_done && m_first);
      chk("load_start",  bus.load_start,  m_busy && m_req && (m_step % 2 == 0));
      chk("write_start", bus.write_start, m_busy && m_req && (m_step % 2 == 1));
      chk("pass_idx",    bus.pass_idx,    m_busy ? (m_step / 2) : (m_done ? PASSES - 1 : bus.pass_idx));
      if (m_busy) chk("bank_sel", bus.bank_sel, (m_step / 2) % 2);
      chk("seq_err",     bus.seq_err,     m_err);
`ifdef SEQ_CYCLE_COUNT_EN
      chk("load_cycles",  bus.load_cycles,  m_lc);
      chk("write_cycles", bus.write_cycles, m_wc);
`endif
      if (bus.ap_start && bus.ap_idle) acc_cyc = cyc;
      if (bus.ap_done && !ad_prev) done_cyc = cyc;
      if (bus.write_done) wd_cyc = cyc;
      if (bus.load_start && !ls_prev) begin n_ls++; banks.push_back(int'(bus.bank_sel)); ls_run = 0; end
      if (bus.load_start) ls_run++;
      if (!bus.load_start && ls_prev) runs.push_back(ls_run);
      if (bus.write_start && !ws_prev) n_ws++;
      if (bus.ap_done) n_done++;
      if (bus.ap_ready) n_rdy++;
    end
    ls_prev = bus.load_start;
    ws_prev = bus.write_start;
    ad_prev = bus.ap_done;
  end

  task automatic clear_mon();
    clr_gen++;
  endtask

  task automatic start_inv(input string tag);
    bus.ap_start = 1;
    tick();
    bus.ap_start = 0;
    chk({tag, "_idle_after_start"}, bus.ap_idle, 0);
    chk({tag, "_load_start_after_start"}, bus.load_start, 1);
  endtask

  task automatic wait_done(input int max, input string tag);
    int i = 0;
    while (!bus.ap_done && i < max) begin tick(); i++; end
    if (!bus.ap_done) begin
      n_chk++;
      $display("FAIL %s_timeout: ap_done=%0b after %0d cycles, expected 1", tag, bus.ap_done, max);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int i;
    bus.ap_start = 0;
    bus.ap_continue = 1;
    rst = 1;
    repeat (3) tick();
    chk("rst_ap_idle", bus.ap_idle, 1);
    chk("rst_ap_done", bus.ap_done, 0);
    chk("rst_ap_ready", bus.ap_ready, 0);
    chk("rst_load_start", bus.load_start, 0);
    chk("rst_write_start", bus.write_start, 0);
    chk("rst_seq_err", bus.seq_err, 0);
    chk("rst_pass_idx", bus.pass_idx, 0);
    chk("rst_bank_sel", bus.bank_sel, 0);
    rst = 0;
    tick();

    // Four passes, ready immediately, done three cycles later
    clear_mon(); tick();
    start_inv("t1");
    wait_done(200, "t1");
    tick();
    chk("t1_load_pulses", n_ls, 4);
    chk("t1_write_pulses", n_ws, 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t1_bank_seq%0d", k), (k < banks.size()) ? banks[k] : 99, k % 2);
    chk("t1_done_after_wdone", done_cyc - wd_cyc, 1);
    chk("t1_ready_pulses", n_rdy, 1);
    chk("t1_done_cycles", n_done, 1);
    chk("t1_idle_end", bus.ap_idle, 1);
    chk("t1_seq_err", bus.seq_err, 0);
`ifdef SEQ_CYCLE_COUNT_EN
    chk("t1_load_cycles", bus.load_cycles, 16);
    chk("t1_write_cycles", bus.write_cycles, 16);
`endif

    // Zero-latency children: ap_done lands 2*PASSES+1 cycles after the accepting cycle
    l_dn = 0; w_dn = 0;
    clear_mon(); tick();
    start_inv("t1b");
`ifdef SEQ_CYCLE_COUNT_EN
    chk("t1b_load_cycles_cleared", bus.load_cycles, 0);
    chk("t1b_write_cycles_cleared", bus.write_cycles, 0);
`endif
    wait_done(100, "t1b");
    tick();
    chk("t1b_min_latency", done_cyc - acc_cyc, 2 * PASSES + 1);

    // ap_continue low for the first five DONE cycles
    l_dn = 3; w_dn = 3;
    bus.ap_continue = 0;
    clear_mon(); tick();
    start_inv("t2");
    wait_done(200, "t2");
    repeat (5) tick();
    chk("t2_still_done", bus.ap_done, 1);
    bus.ap_continue = 1;
    tick();
    chk("t2_idle_after_continue", bus.ap_idle, 1);
    chk("t2_done_cycles", n_done, 6);
    chk("t2_ready_pulses", n_rdy, 1);

    // load_ready held off for seven start cycles
    l_rdy = 7;
    clear_mon(); tick();
    start_inv("t3");
    wait_done(400, "t3");
    tick();
    chk("t3_first_load_start_len", (runs.size() > 0) ? runs[0] : 0, 7);
    chk("t3_load_pulses", n_ls, 4);
    chk("t3_write_pulses", n_ws, 4);
    l_rdy = 1;

    // Stray write_done while the load child is busy
    inj_req++;
    clear_mon(); tick();
    start_inv("t4");
    wait_done(200, "t4");
    tick();
    chk("t4_injected", inj_done, inj_req);
    chk("t4_seq_err_sticky", bus.seq_err, 1);
    chk("t4_write_pulses", n_ws, 4);
    chk("t4_ready_pulses", n_rdy, 1);

    // Reset while pass index 1 waits in WR_WT
    clear_mon(); tick();
    start_inv("t5");
    i = 0;
    while (!(bus.pass_idx == 1 && w_busy && !bus.write_start) && i < 200) begin tick(); i++; end
    chk("t5_reached_wr_wait", bus.pass_idx, 1);
    rst = 1;
    #1;
    chk("t5_rst_write_start", bus.write_start, 0);
    chk("t5_rst_load_start", bus.load_start, 0);
    chk("t5_rst_pass_idx", bus.pass_idx, 0);
    chk("t5_rst_ap_idle", bus.ap_idle, 1);
    chk("t5_rst_ap_done", bus.ap_done, 0);
    chk("t5_rst_seq_err", bus.seq_err, 0);
    tick(); tick();
    rst = 0;
    tick();
    clear_mon(); tick();
    start_inv("t5b");
    wait_done(200, "t5b");
    tick();
    chk("t5b_load_pulses", n_ls, 4);
    chk("t5b_write_pulses", n_ws, 4);
    chk("t5b_seq_err", bus.seq_err, 0);
    chk("t5b_ready_pulses", n_rdy, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
